// File: rtl/arcade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_pkg
//  Description : Shared types and constants for the arcade sprite blocks:
//                motion FSM state enum, heading/trig widths, and a helper
//                that builds the quarter-wave sine ROM contents at
//                elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package arcade_pkg;

    localparam int THETA_W   = 10;    // heading resolution: 1024 steps per turn
    localparam int TRIG_W    = 8;     // signed Q1.7 sin/cos
    localparam int FULL_TURN = 1024;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROT    = 3'd1,
        S_LUT    = 3'd2,
        S_VEL    = 3'd3,
        S_POS    = 3'd4,
        S_WRAP   = 3'd5,
        S_COMMIT = 3'd6
    } motion_state_t;

    // round(127 * sin(pi/2 * k/256)) for k in [0,255].
    // Evaluated with a Q30 Taylor series so the ROM is pure constants after
    // elaboration; 7 terms put the error many orders below one LSB.
    function automatic logic [6:0] quarter_sine(input int k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        longint scaled;
        x    = (64'sd1686629713 * longint'(k)) / 256;    // (pi/2)*2^30 * k/256
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        scaled = (acc * 127 + (64'sd1 <<< 29)) >>> 30;
        return scaled[6:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_motion_if.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_motion_if
//  Description : Control/pose bundle between the frame controller and the
//                ghost motion block.
//                master : drives startOfFrame, rotate_left, rotate_right,
//                         thrust, respawn; observes the committed pose,
//                         busy and frame_done.
//                slave  : the motion block (opposite directions).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ghost_motion_if
    import arcade_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) ();

    logic                       startOfFrame;
    logic                       rotate_left;
    logic                       rotate_right;
    logic                       thrust;
    logic                       respawn;
    logic [$clog2(WIDTH)-1:0]   topLeft_x;
    logic [$clog2(HEIGHT)-1:0]  topLeft_y;
    logic [THETA_W-1:0]         theta;
    logic                       busy;
    logic                       frame_done;

    modport master (
        output startOfFrame, rotate_left, rotate_right, thrust, respawn,
        input  topLeft_x, topLeft_y, theta, busy, frame_done
    );

    modport slave (
        input  startOfFrame, rotate_left, rotate_right, thrust, respawn,
        output topLeft_x, topLeft_y, theta, busy, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/sincos_lut.sv
`default_nettype none
// ============================================================================
//  Module      : sincos_lut
//  Description : Registered sin/cos of a 10-bit heading (1024 steps/turn),
//                signed Q1.7, one cycle latency. A 256-entry quarter-wave
//                ROM is folded across the four quadrants.
//  Ports       : clk, resetN (async, active low)
//                theta   [9:0] heading in
//                sin_out [7:0] signed sin(theta), registered
//                cos_out [7:0] signed cos(theta), registered
//  Revision    : 1.0 - initial release
// ============================================================================
module sincos_lut
    import arcade_pkg::*;
(
    input  wire logic                      clk,
    input  wire logic                      resetN,
    input  wire logic [THETA_W-1:0]        theta,
    output logic signed [TRIG_W-1:0]       sin_out,
    output logic signed [TRIG_W-1:0]       cos_out
);

    logic [6:0] w_rom [0:255];

    for (genvar i = 0; i < 256; i++) begin : g_rom
        localparam logic [6:0] C_VAL = quarter_sine(i);
        assign w_rom[i] = C_VAL;
    end

    logic [1:0]              w_q_sin;
    logic [1:0]              w_q_cos;
    logic [7:0]              w_idx;
    logic [7:0]              w_idx_mirror;
    logic [6:0]              w_mag_sin;
    logic [6:0]              w_mag_cos;
    logic signed [TRIG_W-1:0] w_sin;
    logic signed [TRIG_W-1:0] w_cos;

    // cos(t) = sin(t + quarter turn): same fold with the quadrant advanced.
    assign w_q_sin      = theta[9:8];
    assign w_q_cos      = theta[9:8] + 2'd1;
    assign w_idx        = theta[7:0];
    assign w_idx_mirror = 8'd0 - theta[7:0];

    // Odd quadrants read the ROM mirrored; the mirror of index 0 is the
    // quarter-turn point itself, which lies just past the table.
    always_comb begin
        w_mag_sin = w_rom[w_idx];
        w_mag_cos = w_rom[w_idx];
        if (w_q_sin[0]) begin
            w_mag_sin = (w_idx == 8'd0) ? 7'd127 : w_rom[w_idx_mirror];
        end
        if (w_q_cos[0]) begin
            w_mag_cos = (w_idx == 8'd0) ? 7'd127 : w_rom[w_idx_mirror];
        end
        w_sin = w_q_sin[1] ? -signed'({1'b0, w_mag_sin}) : signed'({1'b0, w_mag_sin});
        w_cos = w_q_cos[1] ? -signed'({1'b0, w_mag_cos}) : signed'({1'b0, w_mag_cos});
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sin_out <= '0;
            cos_out <= '0;
        end else begin
            sin_out <= w_sin;
            cos_out <= w_cos;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ghost_motion.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_motion
//  Description : Per-frame motion controller for the rotating ghost sprite.
//                On startOfFrame it latches the controls, steps the heading,
//                applies thrust or friction to a fixed-point velocity,
//                advances and wraps the position, then commits pose and
//                heading together so the drawer never sees a partial update.
//  Ports       : clk, resetN (async, active low)
//                bus (ghost_motion_if.slave):
//                  in  startOfFrame, rotate_left, rotate_right, thrust, respawn
//                  out topLeft_x, topLeft_y, theta, busy, frame_done
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_motion
    import arcade_pkg::*;
#(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int FRAC           = 6,
    parameter int ROT_STEP       = 8,
    parameter int ACCEL          = 24,
    parameter int MAX_SPEED      = 384,
    parameter int FRICTION_SHIFT = 4,
    parameter int SPAWN_X        = 304,
    parameter int SPAWN_Y        = 224
) (
    input  wire logic       clk,
    input  wire logic       resetN,
    ghost_motion_if.slave   bus
);

    localparam int X_W   = $clog2(WIDTH);
    localparam int Y_W   = $clog2(HEIGHT);
    localparam int PX_W  = X_W + 2 + FRAC;
    localparam int PY_W  = Y_W + 2 + FRAC;
    localparam int VEL_W = $clog2(MAX_SPEED + ACCEL + 1) + 1;
    localparam int ACC_W = TRIG_W + $clog2(ACCEL + 1) + 1;

    localparam logic signed [PX_W-1:0]  C_SPAN_X  = PX_W'(WIDTH * (2 ** FRAC));
    localparam logic signed [PY_W-1:0]  C_SPAN_Y  = PY_W'(HEIGHT * (2 ** FRAC));
    localparam logic signed [PX_W-1:0]  C_SPAWN_X = PX_W'(SPAWN_X * (2 ** FRAC));
    localparam logic signed [PY_W-1:0]  C_SPAWN_Y = PY_W'(SPAWN_Y * (2 ** FRAC));
    localparam logic signed [VEL_W-1:0] C_VMAX    = VEL_W'(MAX_SPEED);
    localparam logic signed [VEL_W-1:0] C_FLIM    = VEL_W'(2 ** FRICTION_SHIFT);
    localparam logic signed [ACC_W-1:0] C_ACCEL   = ACC_W'(ACCEL);
    localparam logic [THETA_W-1:0]      C_ROT     = THETA_W'(ROT_STEP);

    motion_state_t              r_state;
    logic                       r_rot_l;
    logic                       r_rot_r;
    logic                       r_thrust;
    logic                       r_respawn;
    logic [THETA_W-1:0]         r_theta;
    logic signed [PX_W-1:0]     r_px;
    logic signed [PY_W-1:0]     r_py;
    logic signed [VEL_W-1:0]    r_vx;
    logic signed [VEL_W-1:0]    r_vy;
    logic [X_W-1:0]             r_out_x;
    logic [Y_W-1:0]             r_out_y;
    logic [THETA_W-1:0]         r_out_theta;
    logic                       r_busy;
    logic                       r_done;

    logic signed [TRIG_W-1:0]   w_sin;
    logic signed [TRIG_W-1:0]   w_cos;
    logic signed [ACC_W-1:0]    w_prod_x;
    logic signed [ACC_W-1:0]    w_prod_y;
    logic signed [VEL_W-1:0]    w_dx;
    logic signed [VEL_W-1:0]    w_dy;
    logic signed [VEL_W-1:0]    w_vx_next;
    logic signed [VEL_W-1:0]    w_vy_next;

    // The LUT input is the working heading, already stepped by S_ROT, so its
    // registered output is valid during S_VEL.
    sincos_lut u_lut (
        .clk     (clk),
        .resetN  (resetN),
        .theta   (r_theta),
        .sin_out (w_sin),
        .cos_out (w_cos)
    );

    // Screen y grows downward, so heading 0 (up) thrusts toward -y.
    assign w_prod_x = ACC_W'(w_sin) * C_ACCEL;
    assign w_prod_y = -(ACC_W'(w_cos) * C_ACCEL);
    assign w_dx     = VEL_W'(w_prod_x >>> (TRIG_W - 1));
    assign w_dy     = VEL_W'(w_prod_y >>> (TRIG_W - 1));

    function automatic logic signed [VEL_W-1:0] clamp_vel(input logic signed [VEL_W-1:0] v);
        if (v > C_VMAX) begin
            return C_VMAX;
        end else if (v < -C_VMAX) begin
            return -C_VMAX;
        end
        return v;
    endfunction

    // Geometric decay never reaches zero on its own; snap small residues.
    function automatic logic signed [VEL_W-1:0] apply_friction(input logic signed [VEL_W-1:0] v);
        logic signed [VEL_W-1:0] d;
        d = v - (v >>> FRICTION_SHIFT);
        if ((d < C_FLIM) && (d > -C_FLIM)) begin
            d = '0;
        end
        return d;
    endfunction

    always_comb begin
        w_vx_next = r_vx;
        w_vy_next = r_vy;
        if (r_thrust) begin
            w_vx_next = clamp_vel(r_vx + w_dx);
            w_vy_next = clamp_vel(r_vy + w_dy);
        end else begin
            w_vx_next = clamp_vel(apply_friction(r_vx));
            w_vy_next = clamp_vel(apply_friction(r_vy));
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_rot_l     <= 1'b0;
            r_rot_r     <= 1'b0;
            r_thrust    <= 1'b0;
            r_respawn   <= 1'b0;
            r_theta     <= '0;
            r_px        <= C_SPAWN_X;
            r_py        <= C_SPAWN_Y;
            r_vx        <= '0;
            r_vy        <= '0;
            r_out_x     <= X_W'(SPAWN_X);
            r_out_y     <= Y_W'(SPAWN_Y);
            r_out_theta <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Sticky request; the commit below clears it after consuming it.
            if (bus.respawn) begin
                r_respawn <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.startOfFrame) begin
                        r_rot_l  <= bus.rotate_left;
                        r_rot_r  <= bus.rotate_right;
                        r_thrust <= bus.thrust;
                        r_busy   <= 1'b1;
                        r_state  <= S_ROT;
                    end
                end
                S_ROT: begin
                    if (r_rot_l && !r_rot_r) begin
                        r_theta <= r_theta - C_ROT;
                    end else if (r_rot_r && !r_rot_l) begin
                        r_theta <= r_theta + C_ROT;
                    end
                    r_state <= S_LUT;
                end
                S_LUT: begin
                    r_state <= S_VEL;
                end
                S_VEL: begin
                    r_vx    <= w_vx_next;
                    r_vy    <= w_vy_next;
                    r_state <= S_POS;
                end
                S_POS: begin
                    r_px    <= r_px + PX_W'(r_vx);
                    r_py    <= r_py + PY_W'(r_vy);
                    r_state <= S_WRAP;
                end
                S_WRAP: begin
                    // |vel| is below one screen span, so one correction suffices.
                    if (r_px < 0) begin
                        r_px <= r_px + C_SPAN_X;
                    end else if (r_px >= C_SPAN_X) begin
                        r_px <= r_px - C_SPAN_X;
                    end
                    if (r_py < 0) begin
                        r_py <= r_py + C_SPAN_Y;
                    end else if (r_py >= C_SPAN_Y) begin
                        r_py <= r_py - C_SPAN_Y;
                    end
                    r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    if (r_respawn || bus.respawn) begin
                        r_px        <= C_SPAWN_X;
                        r_py        <= C_SPAWN_Y;
                        r_vx        <= '0;
                        r_vy        <= '0;
                        r_theta     <= '0;
                        r_out_x     <= X_W'(SPAWN_X);
                        r_out_y     <= Y_W'(SPAWN_Y);
                        r_out_theta <= '0;
                    end else begin
                        r_out_x     <= r_px[FRAC +: X_W];
                        r_out_y     <= r_py[FRAC +: Y_W];
                        r_out_theta <= r_theta;
                    end
                    r_respawn <= 1'b0;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.topLeft_x  = r_out_x;
    assign bus.topLeft_y  = r_out_y;
    assign bus.theta      = r_out_theta;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ghost_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghost_motion
//  Description : Self-checking bench for ghost_motion. A frame-level
//                reference model (real-valued trig, integer kinematics)
//                predicts the committed pose after every update.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_motion;
    import arcade_pkg::*;

    localparam int WIDTH          = 640;
    localparam int HEIGHT         = 480;
    localparam int FRAC           = 6;
    localparam int ROT_STEP       = 8;
    localparam int ACCEL          = 24;
    localparam int MAX_SPEED      = 384;
    localparam int FRICTION_SHIFT = 4;
    localparam int SPAWN_X        = 304;
    localparam int SPAWN_Y        = 224;
    localparam int SUB            = 1 << FRAC;
    localparam logic [9:0] EXP_BUSY_MASK = 10'b00_0111_1110;  // cycles N+1..N+6

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    ghost_motion_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

    ghost_motion #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FRAC(FRAC), .ROT_STEP(ROT_STEP),
        .ACCEL(ACCEL), .MAX_SPEED(MAX_SPEED), .FRICTION_SHIFT(FRICTION_SHIFT),
        .SPAWN_X(SPAWN_X), .SPAWN_Y(SPAWN_Y)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int m_px, m_py, m_vx, m_vy, m_theta;
    bit m_resp;

    function automatic int sin_ref(input int t);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(t) / 1024.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    function automatic int decay(input int v);
        int d;
        d = v - (v >>> FRICTION_SHIFT);
        if (d < (1 << FRICTION_SHIFT) && d > -(1 << FRICTION_SHIFT)) d = 0;
        return d;
    endfunction

    function automatic int clampv(input int v);
        if (v > MAX_SPEED) return MAX_SPEED;
        if (v < -MAX_SPEED) return -MAX_SPEED;
        return v;
    endfunction

    function automatic int wrapp(input int p, input int span);
        if (p < 0) return p + span;
        if (p >= span) return p - span;
        return p;
    endfunction

    task automatic model_reset();
        m_px = SPAWN_X * SUB; m_py = SPAWN_Y * SUB;
        m_vx = 0; m_vy = 0; m_theta = 0; m_resp = 0;
    endtask

    task automatic model_frame(input bit rl, input bit rr, input bit th);
        int s, c;
        if (rl && !rr)      m_theta = (m_theta + FULL_TURN - ROT_STEP) % FULL_TURN;
        else if (rr && !rl) m_theta = (m_theta + ROT_STEP) % FULL_TURN;
        s = sin_ref(m_theta);
        c = sin_ref((m_theta + FULL_TURN / 4) % FULL_TURN);
        if (th) begin
            m_vx = m_vx + ((s * ACCEL) >>> 7);
            m_vy = m_vy + ((-(c * ACCEL)) >>> 7);
        end else begin
            m_vx = decay(m_vx);
            m_vy = decay(m_vy);
        end
        m_vx = clampv(m_vx);
        m_vy = clampv(m_vy);
        m_px = wrapp(m_px + m_vx, WIDTH * SUB);
        m_py = wrapp(m_py + m_vy, HEIGHT * SUB);
        if (m_resp) begin
            model_reset();
        end
    endtask

    // ---------------- stimulus driver ----------------
    // Runs one frame update starting next cycle and reports what was seen in
    // cycles N+1..N+9 relative to the startOfFrame cycle N.
    task automatic run_frame(input bit rl, input bit rr, input bit th,
                             input bit resp_sof, input int resp_k, input bit sof_busy,
                             output logic [9:0] busy_mask, output int done_at,
                             output bit early, output int ox, output int oy, output int oth);
        int x0, y0, t0;
        @(posedge clk); #1;
        x0 = int'(bus.topLeft_x); y0 = int'(bus.topLeft_y); t0 = int'(bus.theta);
        bus.startOfFrame = 1'b1;
        bus.rotate_left  = rl;
        bus.rotate_right = rr;
        bus.thrust       = th;
        bus.respawn      = resp_sof;
        busy_mask = '0; done_at = -1; early = 1'b0; ox = -1; oy = -1; oth = -1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bus.rotate_left  = 1'($urandom_range(0, 1));
                bus.rotate_right = 1'($urandom_range(0, 1));
                bus.thrust       = 1'($urandom_range(0, 1));
            end
            bus.startOfFrame = sof_busy && (k == 3);
            bus.respawn      = (k == resp_k);
            busy_mask[k] = bus.busy;
            if (bus.frame_done) done_at = (done_at < 0) ? k : 99;
            if (k < 7 && (int'(bus.topLeft_x) != x0 || int'(bus.topLeft_y) != y0 ||
                          int'(bus.theta) != t0)) early = 1'b1;
            if (k == 7) begin
                ox = int'(bus.topLeft_x); oy = int'(bus.topLeft_y); oth = int'(bus.theta);
            end
        end
        bus.respawn = 1'b0;
    endtask

    // Locals shared by the scenario tasks below (one process uses them).
    logic [9:0] g_mask;
    int g_done, g_ox, g_oy, g_oth;
    bit g_early;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.topLeft_x !== 10'(SPAWN_X) || bus.topLeft_y !== 9'(SPAWN_Y) || bus.theta !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_pose: got (%0d,%0d,%0d) want (%0d,%0d,0)",
                     bus.topLeft_x, bus.topLeft_y, bus.theta, SPAWN_X, SPAWN_Y);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.frame_done);
        end
        @(posedge clk); #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_frames();
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, 0, 0, 0, g_mask, g_done, g_early, g_ox, g_oy, g_oth);
            model_frame(0, 0, 0);
            n_checks++;
            if (g_mask !== EXP_BUSY_MASK || g_done !== 7 || g_early) begin
                n_fail++;
                $display("FAIL idle_timing: busy_mask=%b done_at=%0d early=%0d want %b 7 0",
                         g_mask, g_done, g_early, EXP_BUSY_MASK);
            end
            n_checks++;
            if (g_ox !== SPAWN_X || g_oy !== SPAWN_Y || g_oth !== 0) begin
                n_fail++;
                $display("FAIL idle_pose: got (%0d,%0d,%0d) want (%0d,%0d,0)",
                         g_ox, g_oy, g_oth, SPAWN_X, SPAWN_Y);
            end
        end
    endtask

    task automatic test_rotate();
        for (int f = 1; f <= 128; f++) begin
            run_frame(0, 1, 0, 0, 0, f[0], g_mask, g_done, g_early, g_ox, g_oy, g_oth);
            model_frame(0, 1, 0);
            n_checks++;
            if (g_oth !== (f * ROT_STEP) % FULL_TURN || g_oth !== m_theta || g_done !== 7) begin
                n_fail++;
                $display("FAIL rotate_right f=%0d: theta=%0d done_at=%0d want %0d 7",
                         f, g_oth, g_done, (f * ROT_STEP) % FULL_TURN);
            end
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 1, 0, 0, 0, 0, g_mask, g_done, g_early, g_ox, g_oy, g_oth);
            model_frame(1, 1, 0);
            n_checks++;
            if (g_oth !== m_theta) begin
                n_fail++;
                $display("FAIL rotate_both: theta=%0d want %0d", g_oth, m_theta);
            end
        end
    endtask

    // Generic controlled run: constant controls for n frames, checked each frame.
    task automatic test_drive(input string tag, input bit rl, input bit rr, input bit th, input int n);
        for (int f = 0; f < n; f++) begin
            run_frame(rl, rr, th, 0, 0, 0, g_mask, g_done, g_early, g_ox, g_oy, g_oth);
            model_frame(rl, rr, th);
            n_checks++;
            if (g_ox !== (m_px >> FRAC) || g_oy !== (m_py >> FRAC) || g_oth !== m_theta ||
                g_mask !== EXP_BUSY_MASK || g_done !== 7 || g_early) begin
                n_fail++;
                $display("FAIL %s f=%0d: got (%0d,%0d,%0d) mask=%b done=%0d want (%0d,%0d,%0d) %b 7",
                         tag, f, g_ox, g_oy, g_oth, g_mask, g_done,
                         m_px >> FRAC, m_py >> FRAC, m_theta, EXP_BUSY_MASK);
            end
        end
    endtask

    task automatic test_respawn();
        // mid-update pulse
        test_drive("pre_respawn", 0, 1, 1, 4);
        m_resp = 1;
        run_frame(0, 0, 1, 0, 4, 0, g_mask, g_done, g_early, g_ox, g_oy, g_oth);
        model_frame(0, 0, 1);
        n_checks++;
        if (g_ox !== SPAWN_X || g_oy !== SPAWN_Y || g_oth !== 0) begin
            n_fail++;
            $display("FAIL respawn_mid: got (%0d,%0d,%0d) want (%0d,%0d,0)",
                     g_ox, g_oy, g_oth, SPAWN_X, SPAWN_Y);
        end
        test_drive("post_respawn_mid", 0, 0, 0, 2);
        // coincident with startOfFrame
        test_drive("pre_respawn2", 1, 0, 1, 3);
        m_resp = 1;
        run_frame(1, 0, 1, 1, 0, 1, g_mask, g_done, g_early, g_ox, g_oy, g_oth);
        model_frame(1, 0, 1);
        n_checks++;
        if (g_ox !== SPAWN_X || g_oy !== SPAWN_Y || g_oth !== 0 || g_mask !== EXP_BUSY_MASK) begin
            n_fail++;
            $display("FAIL respawn_sof: got (%0d,%0d,%0d) mask=%b want (%0d,%0d,0) %b",
                     g_ox, g_oy, g_oth, g_mask, SPAWN_X, SPAWN_Y, EXP_BUSY_MASK);
        end
        test_drive("post_respawn_sof", 0, 0, 0, 2);
        // pulse while idle: nothing changes until the next commit
        test_drive("pre_respawn3", 0, 1, 1, 3);
        @(posedge clk); #1; bus.respawn = 1'b1;
        @(posedge clk); #1; bus.respawn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (int'(bus.topLeft_x) !== (m_px >> FRAC) || int'(bus.topLeft_y) !== (m_py >> FRAC) ||
            bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL respawn_idle_hold: got (%0d,%0d) done=%b want (%0d,%0d) 0",
                     bus.topLeft_x, bus.topLeft_y, bus.frame_done, m_px >> FRAC, m_py >> FRAC);
        end
        m_resp = 1;
        test_drive("respawn_idle_commit", 0, 0, 1, 1);
        test_drive("post_respawn_idle", 0, 0, 0, 2);
    endtask

    task automatic test_reset_mid();
        test_drive("pre_reset", 0, 1, 1, 6);
        @(posedge clk); #1;
        bus.startOfFrame = 1'b1; bus.thrust = 1'b1;
        @(posedge clk); #1;
        bus.startOfFrame = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        n_checks++;
        if (bus.topLeft_x !== 10'(SPAWN_X) || bus.topLeft_y !== 9'(SPAWN_Y) || bus.theta !== 10'd0 ||
            bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got (%0d,%0d,%0d) busy=%b done=%b want (%0d,%0d,0) 0 0",
                     bus.topLeft_x, bus.topLeft_y, bus.theta, bus.busy, bus.frame_done, SPAWN_X, SPAWN_Y);
        end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (bus.frame_done !== 1'b0 || bus.topLeft_x !== 10'(SPAWN_X)) begin
            n_fail++;
            $display("FAIL reset_hold: done=%b x=%0d want 0 %0d", bus.frame_done, bus.topLeft_x, SPAWN_X);
        end
        resetN = 1'b1;
        model_reset();
        test_drive("after_reset_coast", 0, 0, 0, 3);
    endtask

    task automatic test_random();
        bit rl, rr, th, rs;
        int rk;
        for (int f = 0; f < 150; f++) begin
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            th = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 24) == 0);
            rk = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 6)) : 0;
            run_frame(rl, rr, th, rs, rk, 1'($urandom_range(0, 1)),
                      g_mask, g_done, g_early, g_ox, g_oy, g_oth);
            if (rs || rk != 0) m_resp = 1;
            model_frame(rl, rr, th);
            n_checks++;
            if (g_ox !== (m_px >> FRAC) || g_oy !== (m_py >> FRAC) || g_oth !== m_theta ||
                g_mask !== EXP_BUSY_MASK || g_done !== 7 || g_early) begin
                n_fail++;
                $display("FAIL random f=%0d: got (%0d,%0d,%0d) mask=%b done=%0d want (%0d,%0d,%0d) %b 7",
                         f, g_ox, g_oy, g_oth, g_mask, g_done,
                         m_px >> FRAC, m_py >> FRAC, m_theta, EXP_BUSY_MASK);
            end
        end
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.rotate_left  = 1'b0;
        bus.rotate_right = 1'b0;
        bus.thrust       = 1'b0;
        bus.respawn      = 1'b0;
        model_reset();

        test_reset();
        test_idle_frames();
        test_rotate();
        test_drive("turn_to_east", 0, 1, 0, 32);        // theta = 256
        test_drive("thrust_east", 0, 0, 1, 20);         // vel_x climbs, clamps
        test_drive("cruise_east_wrap", 0, 0, 1, 60);    // x wraps past 639
        test_drive("friction", 0, 0, 0, 60);            // decays to exactly 0
        test_drive("turn_to_north", 1, 0, 0, 32);       // theta = 0
        test_drive("thrust_north_wrap", 0, 0, 1, 100);  // y wraps past 0
        test_respawn();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
